// File: rtl/weight_dma_engine.sv
// weight_dma_engine: burst-read DMA filling one Q/K/V/input CIM buffer per controller request.
// Optional protocol checking (err output) is built in when WDMA_ERR_CHECK_EN is defined.
module weight_dma_engine #(
    parameter int BUS_ADDR_WIDTH = 32,
    parameter int DATA_WIDTH     = 32,
    parameter int BURST_LEN      = 16,
    parameter int TRANSFER_WORDS = 64,
    parameter int BUF_ADDR_WIDTH = 6
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      enable_weight_dma,
    input  logic [BUS_ADDR_WIDTH-1:0] weight_address,
    input  logic [1:0]                weight_sel_qkv,
    output logic                      done_weight_dma,
    output logic                      bus_req,
    output logic [BUS_ADDR_WIDTH-1:0] bus_addr,
    output logic [7:0]                bus_len,
    input  logic                      bus_gnt,
    input  logic                      bus_rvalid,
    input  logic [DATA_WIDTH-1:0]     bus_rdata,
    input  logic                      bus_rlast,
    output logic                      buf_we,
    output logic [1:0]                buf_sel,
    output logic [BUF_ADDR_WIDTH-1:0] buf_addr,
    output logic [DATA_WIDTH-1:0]     buf_wdata,
    output logic                      err
);
    localparam int CW = $clog2(TRANSFER_WORDS + 1);

    typedef enum logic [2:0] {IDLE, REQ, DATA, DONE, HOLD} state_t;

    state_t                    state_q, state_d;
    logic [BUS_ADDR_WIDTH-1:0] base_q, base_d, bus_addr_q, bus_addr_d;
    logic [1:0]                sel_q, sel_d, buf_sel_q, buf_sel_d;
    logic [CW-1:0]             rem_q, rem_d, off_q, off_d;
    logic [7:0]                len_q, len_d, beat_q, beat_d;
    logic                      buf_we_q, buf_we_d;
    logic [BUF_ADDR_WIDTH-1:0] buf_addr_q, buf_addr_d;
    logic [DATA_WIDTH-1:0]     buf_wdata_q, buf_wdata_d;
    logic                      start, last_beat;

    function automatic logic [7:0] burst_len(input logic [CW-1:0] r);
        return (int'(r) >= BURST_LEN) ? 8'(BURST_LEN - 1) : 8'(r - 1'b1);
    endfunction

    // HOLD restarts only on a changed {address, sel}, since enable stays high between loads
    assign start     = enable_weight_dma && (state_q == IDLE || (state_q == HOLD &&
                       (weight_address != base_q || weight_sel_qkv != sel_q)));
    assign last_beat = beat_q == len_q;

    always_comb begin
        state_d     = state_q;
        base_d      = base_q;
        sel_d       = sel_q;
        rem_d       = rem_q;
        off_d       = off_q;
        len_d       = len_q;
        beat_d      = beat_q;
        bus_addr_d  = bus_addr_q;
        buf_sel_d   = buf_sel_q;
        buf_addr_d  = buf_addr_q;
        buf_wdata_d = buf_wdata_q;
        buf_we_d    = 1'b0;
        case (state_q)
            IDLE, HOLD: begin
                if (start) begin
                    base_d     = weight_address;
                    sel_d      = weight_sel_qkv;
                    rem_d      = CW'(TRANSFER_WORDS);
                    off_d      = '0;
                    bus_addr_d = weight_address;
                    len_d      = burst_len(CW'(TRANSFER_WORDS));
                    state_d    = REQ;
                end else if (state_q == HOLD && !enable_weight_dma) begin
                    state_d = IDLE;
                end
            end
            REQ: begin
                if (bus_gnt) begin
                    beat_d  = '0;
                    state_d = DATA;
                end
            end
            DATA: begin
                if (bus_rvalid) begin
                    buf_we_d    = 1'b1;
                    buf_addr_d  = BUF_ADDR_WIDTH'(off_q);
                    buf_wdata_d = bus_rdata;
                    buf_sel_d   = sel_q;
                    off_d       = off_q + 1'b1;
                    rem_d       = rem_q - 1'b1;
                    beat_d      = beat_q + 8'd1;
                    if (last_beat) begin
                        state_d = (rem_d != '0) ? REQ : DONE;
                        if (rem_d != '0) begin
                            bus_addr_d = base_q + BUS_ADDR_WIDTH'(off_d);
                            len_d      = burst_len(rem_d);
                        end
                    end
                end
            end
            DONE:    state_d = HOLD;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            base_q      <= '0;
            sel_q       <= '0;
            rem_q       <= '0;
            off_q       <= '0;
            len_q       <= '0;
            beat_q      <= '0;
            bus_addr_q  <= '0;
            buf_sel_q   <= '0;
            buf_addr_q  <= '0;
            buf_wdata_q <= '0;
            buf_we_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            base_q      <= base_d;
            sel_q       <= sel_d;
            rem_q       <= rem_d;
            off_q       <= off_d;
            len_q       <= len_d;
            beat_q      <= beat_d;
            bus_addr_q  <= bus_addr_d;
            buf_sel_q   <= buf_sel_d;
            buf_addr_q  <= buf_addr_d;
            buf_wdata_q <= buf_wdata_d;
            buf_we_q    <= buf_we_d;
        end
    end

    assign done_weight_dma = state_q == DONE;
    assign bus_req         = state_q == REQ;
    assign bus_addr        = bus_addr_q;
    assign bus_len         = len_q;
    assign buf_we          = buf_we_q;
    assign buf_sel         = buf_sel_q;
    assign buf_addr        = buf_addr_q;
    assign buf_wdata       = buf_wdata_q;

`ifdef WDMA_ERR_CHECK_EN
    logic in_buf_off, err_q, err_d;
    // software disable of the input-buffer target is not wired up yet
    assign in_buf_off = 1'b0;
    assign err_d = err_q || (bus_rvalid && (state_q != DATA || bus_rlast != last_beat)) ||
                   (start && weight_sel_qkv == 2'd3 && in_buf_off);
    always_ff @(posedge clk or posedge rst) begin
        if (rst) err_q <= 1'b0;
        else     err_q <= err_d;
    end
    assign err = err_q;
`else
    logic unused_rlast;
    assign unused_rlast = bus_rlast;
    assign err = 1'b0;
`endif
endmodule

// File: doc/weight_dma_engine.md
# weight_dma_engine

Bus-read DMA that loads one Q, K, V weight block or input block from external memory into the QKV compute-in-memory buffers. It sits directly downstream of `top_controller`. It consumes `enable_weight_dma`, `weight_address` and `weight_sel_qkv`, and returns the `done_weight_dma` pulse that advances the controller's init sequence. The controller holds enable high across consecutive loads, so a new transfer is triggered by enable, address or select changing, not by enable edges alone.

## Interface
Parameters:
- BUS_ADDR_WIDTH, 32, bus/word address width
- DATA_WIDTH, 32, bus and buffer word width
- BURST_LEN, 16, maximum beats per bus burst (power of two, ≥2)
- TRANSFER_WORDS, 64, words per transfer (≥1, need not be a multiple of BURST_LEN)
- BUF_ADDR_WIDTH, 6, buffer address width (2^BUF_ADDR_WIDTH ≥ TRANSFER_WORDS)

Ports:
- clk  in  1  clock, all logic on rising edge
- rst  in  1  asynchronous, active-high reset
- enable_weight_dma  in  1  level request from controller
- weight_address  in  BUS_ADDR_WIDTH  word base address
- weight_sel_qkv  in  2  destination: 0=Q, 1=K, 2=V, 3=input buffer
- done_weight_dma  out  1  one-cycle completion pulse
- bus_req  out  1  burst read request
- bus_addr  out  BUS_ADDR_WIDTH  burst start word address
- bus_len  out  8  beats−1 of current burst
- bus_gnt  in  1  request accepted
- bus_rvalid  in  1  read beat valid
- bus_rdata  in  DATA_WIDTH  read beat data
- bus_rlast  in  1  final beat marker
- buf_we  out  1  buffer write strobe
- buf_sel  out  2  latched destination select
- buf_addr  out  BUF_ADDR_WIDTH  word offset in buffer
- buf_wdata  out  DATA_WIDTH  write data
- err  out  1  sticky protocol error

## Operation
- States: IDLE, REQ, DATA, DONE, HOLD.
- IDLE: when enable=1, latch base=weight_address, sel=weight_sel_qkv, set remaining=TRANSFER_WORDS, set offset=0, then go to REQ.
- REQ: drive bus_req=1, bus_addr=base+offset, bus_len=min(BURST_LEN,remaining)−1. Hold these until bus_gnt=1, then go to DATA with beat counter=0.
- DATA: each bus_rvalid beat registers buf_we=1, buf_addr=offset, buf_wdata=bus_rdata, buf_sel=sel, then increments offset and the beat counter and decrements remaining.
  - The burst ends when the beat counter reaches bus_len+1.
  - At burst end, go to REQ if remaining>0, otherwise go to DONE.
- DONE: done_weight_dma=1 for exactly one cycle, then go to HOLD.
- HOLD: remember the completed {address, sel}.
  - enable=0: go to IDLE.
  - enable=1 with weight_address or weight_sel_qkv differing from the latched values: start a new transfer directly (same actions as IDLE).
  - Otherwise: stay in HOLD with no re-transfer.
- enable dropping mid-transfer does not abort. The transfer completes and done still pulses.
- Input changes during REQ or DATA are ignored; only the latched values are used.
- Address arithmetic is modulo 2^BUS_ADDR_WIDTH.
- The last burst is shortened for a remainder, e.g. TRANSFER_WORDS=40 gives bursts of 16, 16, 8.
- Outputs after reset: done_weight_dma=0, bus_req=0, bus_addr=0, bus_len=0, buf_we=0, buf_sel=0, buf_addr=0, buf_wdata=0, err=0.
- State after reset: IDLE with latched registers cleared.
- Reset asserted mid-transfer returns to IDLE immediately. Any in-flight bus beats after reset release are ignored while not in DATA.

## Timing
- enable sampled at edge t in IDLE gives bus_req=1 from t+1.
- bus_gnt sampled at edge g gives bus_req=0 from g+1. A beat may arrive at g+1 at the earliest.
- bus_rvalid at edge b gives buf_we=1 during cycle b+1. Throughput is one word per cycle.
- The last beat at edge b gives done_weight_dma=1 during cycle b+1, coincident with the final buf_we.
- Between bursts, the next bus_req is asserted in the cycle after the last beat's edge.
- Minimum transfer latency is 1 (REQ) + bursts×(grant wait + beats) + 1 cycles.

## Configuration
- Macro: WDMA_ERR_CHECK_EN.
- Defined:
  - err is set and held until reset on any of:
    - bus_rlast=1 on a beat other than the final beat of a burst;
    - bus_rlast=0 on the final beat;
    - bus_rvalid=1 outside DATA;
    - weight_sel_qkv=3 when the input-buffer target is disabled by software. This condition is exposed as a wire tied to 0.
  - Transfer behaviour is otherwise unchanged; bursts still end by beat count.
- Undefined: bus_rlast is ignored, err is tied to 0, no check logic is present.

## Test plan
- Defaults, base=0x100, sel=0, enable held, zero-wait bus: four bursts at 0x100/0x110/0x120/0x130, each with bus_len=15. buf_addr 0..63 with buf_sel=0. Exactly one done pulse, then HOLD with no further bus_req.
- Controller sequence with enable held: {0x8,0}, then change to {0x9,1} and {0xA,2} one cycle after each done. Three transfers, three done pulses, and buf_sel follows 0, 1, 2.
- TRANSFER_WORDS=40, base=0xFFFFFFF0: bursts at 0xFFFFFFF0 (len 15), 0x00000000 (len 15), 0x00000010 (len 7). 40 writes and one done.
- bus_gnt delayed 5 cycles and bus_rvalid gapped every other cycle: bus_req held stable until grant, buf_addr contiguous, and done after the 64th write.
- rst pulsed during the 20th beat: all outputs 0 at once. Re-raising enable restarts from offset 0 and finishes with 64 writes.
- With WDMA_ERR_CHECK_EN, bus_rlast asserted on beat 10 of the first burst: err=1 from the next cycle and stays 1. The transfer still completes 64 writes and done pulses.
